pipelined_control_unit: RTL and testbench
=========================================

# pipelined_control_unit

Parametrised next-generation control path for the pipelined RV32I core. Decodes the Decode-stage instruction fields into datapath controls, then carries them through the D→E, E→M and M→W control pipeline registers with bubble insertion on `flush_e`. Compared with the previous single-stage decoder, it adds:
- a 4-bit ALU operation set covering shifts, xor and sltu;
- U-type (lui) and jump support;
- full branch-condition evaluation producing `pcsrc_e`;
- a pipelined illegal-instruction flag.

## Interface
Parameters:
- `ALUCTRL_W`, 4: ALU control width; must be ≥4; bits above bit 3 are driven 0.
- `EXT_BRANCH`, 1:
  - 1: support beq/bne/blt/bge/bltu/bgeu.
  - 0: support only beq/bne; other branch funct3 values decode as illegal.

Ports:
- `clk`  in  1  core clock; all registers rise-edge.
- `reset`  in  1  synchronous, active-high.
- `opcode_d`  in  7  instr[6:0] in Decode.
- `funct3_d`  in  3  instr[14:12].
- `funct7b5_d`  in  1  instr[30].
- `flush_e`  in  1  from hazard unit; loads a bubble into E.
- `zero_e`, `lt_e`, `ltu_e`  in  1 each  ALU flags: A==B, signed A<B, unsigned A<B.
- `immsrc_d`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `regwrite_e`, `regwrite_m`, `regwrite_w`  out  1 each.
- `resultsrc_e`, `resultsrc_m`, `resultsrc_w`  out  2 each  00 ALU, 01 mem, 10 PC+4, 11 imm.
- `memwrite_m`  out  1.
- `alusrc_e`  out  1  1 = immediate operand.
- `alucontrol_e`  out  ALUCTRL_W.
- `pcsrc_e`  out  1  redirect fetch to the branch/jump target.
- `illegal_w`  out  1  the instruction now in Writeback was undecodable.

## Operation
Main decode (combinational, D stage), by opcode:
- 0000011 (lw):
  - regwrite 1, immsrc I, alusrc 1, resultsrc 01, aluop 00.
- 0100011 (sw):
  - memwrite 1, immsrc S, alusrc 1, aluop 00.
- 0110011 (R-type):
  - regwrite 1, alusrc 0, resultsrc 00, aluop 10.
- 0010011 (I-ALU):
  - regwrite 1, immsrc I, alusrc 1, resultsrc 00, aluop 10.
- 1100011 (branch):
  - branch 1, immsrc B, alusrc 0, aluop 01.
- 1101111 (jal):
  - jump 1, regwrite 1, immsrc J, resultsrc 10.
- 0110111 (lui):
  - regwrite 1, immsrc U, resultsrc 11.
- Any other opcode:
  - regwrite, memwrite, branch, jump all 0; illegal 1.
- Unlisted controls are 0.

ALU decode:
- aluop 00 → add 0000.
- aluop 01 → sub 0001.
- aluop 10, by funct3:
  - 000: sub if opcode_d[5]&funct7b5_d, else add.
  - 001: sll 0111.
  - 010: slt 0101.
  - 011: sltu 0110.
  - 100: xor 0100.
  - 101: sra 1001 if funct7b5_d, else srl 1000.
  - 110: or 0011.
  - 111: and 0010.

Branch condition (E stage), using funct3 carried to E:
- 000 zero_e; 001 !zero_e; 100 lt_e; 101 !lt_e; 110 ltu_e; 111 !ltu_e.
- 010 and 011 are illegal at decode: branch 0, illegal 1.
- `pcsrc_e = (branch_e & cond) | jump_e`.

Pipeline registers:
- D→E holds regwrite, resultsrc, memwrite, jump, branch, alucontrol, alusrc, funct3, illegal.
- E→M holds regwrite, resultsrc, memwrite, illegal.
- M→W holds regwrite, resultsrc, illegal.
- Bubble = all control fields 0, including alucontrol and funct3.

## Timing
- Reset: every pipeline register is zeroed on the clock edge with `reset`=1.
  - After reset, all registered outputs are 0 and `pcsrc_e`=0.
- Priority at the D→E register: reset > flush_e > load.
- E→M and M→W always advance and are cleared only by reset; no stall input exists.
- Latency from decode in cycle N:
  - E outputs valid in N+1, M in N+2, W in N+3.
  - `immsrc_d` is combinational in cycle N.
- `pcsrc_e` is combinational from E registers and the flags, with no extra cycle.
- A flush in the same cycle as a valid decode discards that instruction: it never reaches M or W.
- A flush asserted while a branch is in E still lets that branch resolve `pcsrc_e` in the current cycle; the bubble appears next cycle.
- Reset asserted mid-stream clears all stages in one edge; nothing in flight survives.

## Test plan
- Reset, then decode 0110011, funct3 000, funct7b5 1:
  - N+1: alucontrol_e=0001, regwrite_e=1, alusrc_e=0.
  - N+3: regwrite_w=1, resultsrc_w=00.
- lw (0000011), then flush_e=1 in that same cycle:
  - N+1: all E outputs 0.
  - N+2: regwrite_m=0, memwrite_m=0.
- Branch funct3 101 with lt_e=0:
  - pcsrc_e=1.
- Same branch with lt_e=1:
  - pcsrc_e=0.
- Repeat the funct3 101 branch with EXT_BRANCH=0:
  - decoded illegal; branch_e=0; illegal_w=1 at N+3.
- jal (1101111):
  - immsrc_d=011.
  - N+1: pcsrc_e=1 regardless of flags, resultsrc_e=10.
- Opcode 1111111:
  - illegal_w=1 at N+3, regwrite_w=0, memwrite_m=0 at N+2.
- Reset raised while an sw is in M:
  - next edge: memwrite_m=0 and all outputs 0.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit_if
// Brief    : Decode fields, ALU flags and pipelined control outputs of the
//            RV32I control path, bundled with core-side and unit-side views.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_control_unit_if #(
  parameter int ALUCTRL_W = 4
);
  logic [6:0]           opcode_d;
  logic [2:0]           funct3_d;
  logic                 funct7b5_d;
  logic                 flush_e;
  logic                 zero_e;
  logic                 lt_e;
  logic                 ltu_e;
  logic [2:0]           immsrc_d;
  logic                 regwrite_e;
  logic                 regwrite_m;
  logic                 regwrite_w;
  logic [1:0]           resultsrc_e;
  logic [1:0]           resultsrc_m;
  logic [1:0]           resultsrc_w;
  logic                 memwrite_m;
  logic                 alusrc_e;
  logic [ALUCTRL_W-1:0] alucontrol_e;
  logic                 pcsrc_e;
  logic                 illegal_w;

  modport master (
    output opcode_d, funct3_d, funct7b5_d, flush_e, zero_e, lt_e, ltu_e,
    input  immsrc_d, regwrite_e, regwrite_m, regwrite_w,
           resultsrc_e, resultsrc_m, resultsrc_w, memwrite_m,
           alusrc_e, alucontrol_e, pcsrc_e, illegal_w
  );

  modport slave (
    input  opcode_d, funct3_d, funct7b5_d, flush_e, zero_e, lt_e, ltu_e,
    output immsrc_d, regwrite_e, regwrite_m, regwrite_w,
           resultsrc_e, resultsrc_m, resultsrc_w, memwrite_m,
           alusrc_e, alucontrol_e, pcsrc_e, illegal_w
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_unit
// Brief    : RV32I decode plus D->E, E->M, M->W control pipeline registers,
//            branch resolution in E and a pipelined illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_control_unit #(
  parameter int ALUCTRL_W  = 4,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  wire                      clk,
  input  wire                      reset,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;

  localparam logic [3:0] c_alu_add  = 4'b0000;
  localparam logic [3:0] c_alu_sub  = 4'b0001;
  localparam logic [3:0] c_alu_and  = 4'b0010;
  localparam logic [3:0] c_alu_or   = 4'b0011;
  localparam logic [3:0] c_alu_xor  = 4'b0100;
  localparam logic [3:0] c_alu_slt  = 4'b0101;
  localparam logic [3:0] c_alu_sltu = 4'b0110;
  localparam logic [3:0] c_alu_sll  = 4'b0111;
  localparam logic [3:0] c_alu_srl  = 4'b1000;
  localparam logic [3:0] c_alu_sra  = 4'b1001;

  typedef struct packed {
    logic                 regwrite;
    logic [1:0]           resultsrc;
    logic                 memwrite;
    logic                 jump;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 alusrc;
    logic [2:0]           funct3;
    logic                 illegal;
  } ctrl_e_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       illegal;
  } ctrl_w_t;

  logic       w_branch_legal;
  logic       w_regwrite_d;
  logic [1:0] w_resultsrc_d;
  logic       w_memwrite_d;
  logic       w_jump_d;
  logic       w_branch_d;
  logic [1:0] w_aluop_d;
  logic       w_alusrc_d;
  logic [2:0] w_immsrc_d;
  logic       w_illegal_d;
  logic [3:0] w_alucode_d;
  logic       w_cond_e;

  ctrl_e_t w_ctrl_e_d, r_ctrl_e_q;
  ctrl_m_t w_ctrl_m_d, r_ctrl_m_q;
  ctrl_w_t w_ctrl_w_d, r_ctrl_w_q;

  // Branch funct3 010/011 are never legal; the reduced core also drops the compares.
  if (EXT_BRANCH) begin : g_ext_branch
    assign w_branch_legal = (bus.funct3_d[2:1] != 2'b01);
  end else begin : g_base_branch
    assign w_branch_legal = (bus.funct3_d[2:1] == 2'b00);
  end

  always_comb begin
    w_regwrite_d  = 1'b0;
    w_resultsrc_d = 2'b00;
    w_memwrite_d  = 1'b0;
    w_jump_d      = 1'b0;
    w_branch_d    = 1'b0;
    w_aluop_d     = 2'b00;
    w_alusrc_d    = 1'b0;
    w_immsrc_d    = 3'b000;
    w_illegal_d   = 1'b0;
    case (bus.opcode_d)
      c_op_load: begin
        w_regwrite_d  = 1'b1;
        w_alusrc_d    = 1'b1;
        w_resultsrc_d = 2'b01;
      end
      c_op_store: begin
        w_memwrite_d = 1'b1;
        w_immsrc_d   = 3'b001;
        w_alusrc_d   = 1'b1;
      end
      c_op_rtype: begin
        w_regwrite_d = 1'b1;
        w_aluop_d    = 2'b10;
      end
      c_op_itype: begin
        w_regwrite_d = 1'b1;
        w_alusrc_d   = 1'b1;
        w_aluop_d    = 2'b10;
      end
      c_op_branch: begin
        w_branch_d  = w_branch_legal;
        w_illegal_d = ~w_branch_legal;
        w_immsrc_d  = 3'b010;
        w_aluop_d   = 2'b01;
      end
      c_op_jal: begin
        w_jump_d      = 1'b1;
        w_regwrite_d  = 1'b1;
        w_immsrc_d    = 3'b011;
        w_resultsrc_d = 2'b10;
      end
      c_op_lui: begin
        w_regwrite_d  = 1'b1;
        w_immsrc_d    = 3'b100;
        w_resultsrc_d = 2'b11;
      end
      default: w_illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    w_alucode_d = c_alu_add;
    case (w_aluop_d)
      2'b01: w_alucode_d = c_alu_sub;
      2'b10: begin
        case (bus.funct3_d)
          3'b000:  w_alucode_d = (bus.opcode_d[5] & bus.funct7b5_d) ? c_alu_sub : c_alu_add;
          3'b001:  w_alucode_d = c_alu_sll;
          3'b010:  w_alucode_d = c_alu_slt;
          3'b011:  w_alucode_d = c_alu_sltu;
          3'b100:  w_alucode_d = c_alu_xor;
          3'b101:  w_alucode_d = bus.funct7b5_d ? c_alu_sra : c_alu_srl;
          3'b110:  w_alucode_d = c_alu_or;
          default: w_alucode_d = c_alu_and;
        endcase
      end
      default: w_alucode_d = c_alu_add;
    endcase
  end

  always_comb begin
    w_ctrl_e_d = '0;
    if (!bus.flush_e) begin
      w_ctrl_e_d.regwrite   = w_regwrite_d;
      w_ctrl_e_d.resultsrc  = w_resultsrc_d;
      w_ctrl_e_d.memwrite   = w_memwrite_d;
      w_ctrl_e_d.jump       = w_jump_d;
      w_ctrl_e_d.branch     = w_branch_d;
      w_ctrl_e_d.alucontrol = ALUCTRL_W'(w_alucode_d);
      w_ctrl_e_d.alusrc     = w_alusrc_d;
      w_ctrl_e_d.funct3     = bus.funct3_d;
      w_ctrl_e_d.illegal    = w_illegal_d;
    end
    w_ctrl_m_d.regwrite  = r_ctrl_e_q.regwrite;
    w_ctrl_m_d.resultsrc = r_ctrl_e_q.resultsrc;
    w_ctrl_m_d.memwrite  = r_ctrl_e_q.memwrite;
    w_ctrl_m_d.illegal   = r_ctrl_e_q.illegal;
    w_ctrl_w_d.regwrite  = r_ctrl_m_q.regwrite;
    w_ctrl_w_d.resultsrc = r_ctrl_m_q.resultsrc;
    w_ctrl_w_d.illegal   = r_ctrl_m_q.illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_e_q <= '0;
      r_ctrl_m_q <= '0;
      r_ctrl_w_q <= '0;
    end else begin
      r_ctrl_e_q <= w_ctrl_e_d;
      r_ctrl_m_q <= w_ctrl_m_d;
      r_ctrl_w_q <= w_ctrl_w_d;
    end
  end

  always_comb begin
    case (r_ctrl_e_q.funct3)
      3'b000:  w_cond_e = bus.zero_e;
      3'b001:  w_cond_e = ~bus.zero_e;
      3'b100:  w_cond_e = bus.lt_e;
      3'b101:  w_cond_e = ~bus.lt_e;
      3'b110:  w_cond_e = bus.ltu_e;
      3'b111:  w_cond_e = ~bus.ltu_e;
      default: w_cond_e = 1'b0;
    endcase
  end

  assign bus.immsrc_d     = w_immsrc_d;
  assign bus.regwrite_e   = r_ctrl_e_q.regwrite;
  assign bus.resultsrc_e  = r_ctrl_e_q.resultsrc;
  assign bus.alusrc_e     = r_ctrl_e_q.alusrc;
  assign bus.alucontrol_e = r_ctrl_e_q.alucontrol;
  assign bus.pcsrc_e      = (r_ctrl_e_q.branch & w_cond_e) | r_ctrl_e_q.jump;
  assign bus.regwrite_m   = r_ctrl_m_q.regwrite;
  assign bus.resultsrc_m  = r_ctrl_m_q.resultsrc;
  assign bus.memwrite_m   = r_ctrl_m_q.memwrite;
  assign bus.regwrite_w   = r_ctrl_w_q.regwrite;
  assign bus.resultsrc_w  = r_ctrl_w_q.resultsrc;
  assign bus.illegal_w    = r_ctrl_w_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_control_unit
// Brief    : Directed and random decode streams into a full-branch unit and a
//            beq/bne-only unit, checked against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

  typedef struct {
    bit       regwrite;
    bit [1:0] resultsrc;
    bit       memwrite;
    bit       jump;
    bit       branch;
    bit [3:0] alu;
    bit       alusrc;
    bit [2:0] funct3;
    bit       illegal;
    bit [2:0] immsrc;
  } ref_ctrl_t;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       flush;
  logic [3:0] opa, opb;
  int n_vec = 0;
  int n_err = 0;

  ref_ctrl_t pe[2], pm[2], pw[2];

  pipelined_control_unit_if #(.ALUCTRL_W(4)) bus_full ();
  pipelined_control_unit_if #(.ALUCTRL_W(6)) bus_base ();

  pipelined_control_unit #(.ALUCTRL_W(4), .EXT_BRANCH(1'b1)) dut_full (
    .clk(clk), .reset(rst), .bus(bus_full.slave));
  pipelined_control_unit #(.ALUCTRL_W(6), .EXT_BRANCH(1'b0)) dut_base (
    .clk(clk), .reset(rst), .bus(bus_base.slave));

  always #5 clk = ~clk;

  // Both units see the same instruction stream and the same operand flags.
  always_comb begin
    bus_full.opcode_d   = op;    bus_base.opcode_d   = op;
    bus_full.funct3_d   = f3;    bus_base.funct3_d   = f3;
    bus_full.funct7b5_d = f7;    bus_base.funct7b5_d = f7;
    bus_full.flush_e    = flush; bus_base.flush_e    = flush;
    bus_full.zero_e = (opa == opb);                  bus_base.zero_e = (opa == opb);
    bus_full.lt_e   = ($signed(opa) < $signed(opb)); bus_base.lt_e   = ($signed(opa) < $signed(opb));
    bus_full.ltu_e  = (opa < opb);                   bus_base.ltu_e  = (opa < opb);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic ref_ctrl_t ref_decode(bit [6:0] o, bit [2:0] fn3, bit fn7, bit ext);
    bit [3:0] alu_by_f3 [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
    ref_ctrl_t c = '{default: 0};
    bit legal_br;
    c.funct3 = fn3;
    if (o == 7'b0000011) begin                     // lw
      c.regwrite = 1; c.alusrc = 1; c.resultsrc = 2'b01;
    end else if (o == 7'b0100011) begin            // sw
      c.memwrite = 1; c.alusrc = 1; c.immsrc = 3'b001;
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      c.regwrite = 1;
      c.alusrc   = (o == 7'b0010011);
      c.alu      = alu_by_f3[fn3];
      if (fn3 == 3'd0 && o == 7'b0110011 && fn7) c.alu = 4'h1;
      if (fn3 == 3'd5 && fn7) c.alu = 4'h9;
    end else if (o == 7'b1100011) begin            // branch
      legal_br  = ext ? (fn3 != 3'd2 && fn3 != 3'd3) : (fn3 <= 3'd1);
      c.branch  = legal_br;
      c.illegal = !legal_br;
      c.immsrc  = 3'b010;
      c.alu     = 4'h1;
    end else if (o == 7'b1101111) begin            // jal
      c.jump = 1; c.regwrite = 1; c.immsrc = 3'b011; c.resultsrc = 2'b10;
    end else if (o == 7'b0110111) begin            // lui
      c.regwrite = 1; c.immsrc = 3'b100; c.resultsrc = 2'b11;
    end else begin
      c.illegal = 1;
    end
    return c;
  endfunction

  function automatic bit ref_taken(bit [2:0] fn3, bit [3:0] a, bit [3:0] b);
    case (fn3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  task automatic check_all();
    ref_ctrl_t d0 = ref_decode(op, f3, f7, 1'b1);
    ref_ctrl_t d1 = ref_decode(op, f3, f7, 1'b0);
    chk("full.immsrc_d",     32'(bus_full.immsrc_d),     32'(d0.immsrc));
    chk("full.regwrite_e",   32'(bus_full.regwrite_e),   32'(pe[0].regwrite));
    chk("full.resultsrc_e",  32'(bus_full.resultsrc_e),  32'(pe[0].resultsrc));
    chk("full.alusrc_e",     32'(bus_full.alusrc_e),     32'(pe[0].alusrc));
    chk("full.alucontrol_e", 32'(bus_full.alucontrol_e), 32'(pe[0].alu));
    chk("full.pcsrc_e",      32'(bus_full.pcsrc_e),
        32'(pe[0].jump | (pe[0].branch & ref_taken(pe[0].funct3, opa, opb))));
    chk("full.regwrite_m",   32'(bus_full.regwrite_m),   32'(pm[0].regwrite));
    chk("full.resultsrc_m",  32'(bus_full.resultsrc_m),  32'(pm[0].resultsrc));
    chk("full.memwrite_m",   32'(bus_full.memwrite_m),   32'(pm[0].memwrite));
    chk("full.regwrite_w",   32'(bus_full.regwrite_w),   32'(pw[0].regwrite));
    chk("full.resultsrc_w",  32'(bus_full.resultsrc_w),  32'(pw[0].resultsrc));
    chk("full.illegal_w",    32'(bus_full.illegal_w),    32'(pw[0].illegal));
    chk("base.immsrc_d",     32'(bus_base.immsrc_d),     32'(d1.immsrc));
    chk("base.regwrite_e",   32'(bus_base.regwrite_e),   32'(pe[1].regwrite));
    chk("base.alucontrol_e", 32'(bus_base.alucontrol_e), 32'(pe[1].alu));
    chk("base.pcsrc_e",      32'(bus_base.pcsrc_e),
        32'(pe[1].jump | (pe[1].branch & ref_taken(pe[1].funct3, opa, opb))));
    chk("base.memwrite_m",   32'(bus_base.memwrite_m),   32'(pm[1].memwrite));
    chk("base.regwrite_w",   32'(bus_base.regwrite_w),   32'(pw[1].regwrite));
    chk("base.illegal_w",    32'(bus_base.illegal_w),    32'(pw[1].illegal));
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pe[k] = '{default: 0}; pm[k] = '{default: 0}; pw[k] = '{default: 0};
      end else begin
        pw[k] = pm[k];
        pm[k] = pe[k];
        pe[k] = flush ? '{default: 0} : ref_decode(op, f3, f7, (k == 0));
      end
    end
  endtask

  // One cycle: drive, check mid-cycle, then advance the model with the edge.
  task automatic apply(input bit [6:0] o, input bit [2:0] fn3, input bit fn7,
                       input bit fl, input bit rs, input bit [3:0] a, input bit [3:0] b);
    op = o; f3 = fn3; f7 = fn7; flush = fl; rst = rs; opa = a; opb = b;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic nop(input bit [3:0] a, input bit [3:0] b);
    apply(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, a, b);
  endtask

  initial begin
    bit [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b0110111};
    bit [6:0] ro;
    op = 7'b0; f3 = 3'd0; f7 = 1'b0; flush = 1'b0; rst = 1'b1; opa = 4'd0; opb = 4'd0;
    @(posedge clk);
    model_edge();
    #1;

    apply(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  // sub
    nop(4'd0, 4'd0); nop(4'd0, 4'd0); nop(4'd0, 4'd0);
    apply(7'b0000011, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);  // lw flushed
    nop(4'd0, 4'd0); nop(4'd0, 4'd0);
    apply(7'b1100011, 3'd5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);  // bge
    nop(4'd3, 4'd1);                                        // lt=0 -> taken
    apply(7'b1100011, 3'd5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    nop(4'hF, 4'd1);                                        // lt=1 -> not taken
    nop(4'd0, 4'd0); nop(4'd0, 4'd0);
    apply(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);  // jal
    apply(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd9);  // flush while jal in E
    nop(4'd5, 4'd5);
    apply(7'b1111111, 3'd7, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);  // illegal opcode
    nop(4'd0, 4'd0); nop(4'd0, 4'd0); nop(4'd0, 4'd0);
    apply(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);  // sw
    nop(4'd0, 4'd0);
    apply(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);  // reset with sw in M
    nop(4'd0, 4'd0); nop(4'd0, 4'd0);

    for (int i = 0; i < 600; i++) begin
      int sel = $urandom_range(0, 8);
      ro = (sel < 7) ? ops[sel] : 7'($urandom);
      apply(ro, 3'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3),
            4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
